// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle RV32M divider.
package div_pkg;

   localparam int DEF_XLEN = 32;

   typedef enum logic [2:0] {
      S_IDLE = 3'b001,
      S_CALC = 3'b010,
      S_DONE = 3'b100
   } state_t;

   localparam logic [DEF_XLEN-1:0] DIV_BY_ZERO_Q = '1;
   localparam logic [DEF_XLEN-1:0] INT_MIN       = 32'h8000_0000;
   localparam logic [DEF_XLEN-1:0] NEG_ONE       = '1;

endpackage

// File: rtl/div_if.sv
// Core-side divide request/result handshake shared with the multiplier.
interface div_if
   import div_pkg::*;
#(
   parameter int XLEN = DEF_XLEN
) ();

   logic            enable_i;
   logic [XLEN-1:0] first_operand_i;
   logic [XLEN-1:0] second_operand_i;
   logic            signed_i;
   logic            rem_i;
   logic            hold_o;
   logic [XLEN-1:0] result_o;

   modport master (
      output enable_i, first_operand_i, second_operand_i, signed_i, rem_i,
      input  hold_o, result_o
   );

   modport slave (
      input  enable_i, first_operand_i, second_operand_i, signed_i, rem_i,
      output hold_o, result_o
   );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step
   import div_pkg::*;
#(
   parameter int XLEN = DEF_XLEN
) (
   input  logic [XLEN-1:0] rem_in,
   input  logic            dividend_bit,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_out,
   output logic            q_bit
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   assign shifted = {rem_in, dividend_bit};
   assign diff    = shifted - {1'b0, divisor};
   // The extra top bit acts as the borrow: clear means the subtraction fit.
   assign q_bit   = ~diff[XLEN];
   assign rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, BITS_PER_CYCLE quotient bits per cycle.
//
// state  | meaning
// IDLE   | waiting for enable_i; latches operands, resolves special cases
// CALC   | restoring iterations in progress
// DONE   | result_o valid, hold_o released for one cycle
module div_unit
   import div_pkg::*;
#(
   parameter int XLEN           = DEF_XLEN,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic stall,
   div_if.slave bus
);

   localparam int CW = $clog2(XLEN);

   state_t state, state_nxt;

   logic [XLEN-1:0] quo_q;
   logic [XLEN-1:0] rem_q;
   logic [XLEN-1:0] dvs_q;
   logic [XLEN-1:0] result_q;
   logic [CW-1:0]   cnt_q;
   logic            neg_quo_q;
   logic            neg_rem_q;
   logic            rem_sel_q;

   logic            a_neg, b_neg;
   logic [XLEN-1:0] a_abs, b_abs;
   logic            div_zero, overflow, special;
   logic            last_step, last_cycle;
   logic [XLEN-1:0] fixed_result;

   logic [BITS_PER_CYCLE:0][XLEN-1:0] rem_chain;
   logic [BITS_PER_CYCLE-1:0]         q_bits;

   assign a_neg    = bus.signed_i & bus.first_operand_i[XLEN-1];
   assign b_neg    = bus.signed_i & bus.second_operand_i[XLEN-1];
   assign a_abs    = a_neg ? -bus.first_operand_i  : bus.first_operand_i;
   assign b_abs    = b_neg ? -bus.second_operand_i : bus.second_operand_i;
   assign div_zero = (bus.second_operand_i == '0);
   assign overflow = bus.signed_i && (bus.first_operand_i == INT_MIN)
                     && (bus.second_operand_i == NEG_ONE);
   assign special  = div_zero | overflow;

   assign last_step  = (cnt_q == CW'(XLEN - BITS_PER_CYCLE));
   assign last_cycle = (state == S_DONE);

   // quo_q doubles as the dividend shift register: its MSBs feed the step chain
   // while resolved quotient bits enter at the bottom.
   assign rem_chain[0] = rem_q;

   for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
      div_step #(.XLEN(XLEN)) u_step (
         .rem_in      (rem_chain[k]),
         .dividend_bit(quo_q[XLEN-1-k]),
         .divisor     (dvs_q),
         .rem_out     (rem_chain[k+1]),
         .q_bit       (q_bits[BITS_PER_CYCLE-1-k])
      );
   end

   assign fixed_result = rem_sel_q ? (neg_rem_q ? -rem_q : rem_q)
                                   : (neg_quo_q ? -quo_q : quo_q);

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (bus.enable_i) state_nxt = special ? S_DONE : S_CALC;
         S_CALC: begin
            if (!bus.enable_i)  state_nxt = S_IDLE;
            else if (last_step) state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else if (!stall) begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         quo_q     <= '0;
         rem_q     <= '0;
         dvs_q     <= '0;
         result_q  <= '0;
         cnt_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         rem_sel_q <= 1'b0;
      end else if (!stall) begin
         case (state)
            S_IDLE: begin
               if (bus.enable_i) begin
                  cnt_q     <= '0;
                  rem_sel_q <= bus.rem_i;
                  dvs_q     <= b_abs;
                  // Special results are stored already signed, so no fix-up applies.
                  if (div_zero) begin
                     quo_q     <= DIV_BY_ZERO_Q;
                     rem_q     <= bus.first_operand_i;
                     neg_quo_q <= 1'b0;
                     neg_rem_q <= 1'b0;
                  end else if (overflow) begin
                     quo_q     <= INT_MIN;
                     rem_q     <= '0;
                     neg_quo_q <= 1'b0;
                     neg_rem_q <= 1'b0;
                  end else begin
                     quo_q     <= a_abs;
                     rem_q     <= '0;
                     neg_quo_q <= a_neg ^ b_neg;
                     neg_rem_q <= a_neg;
                  end
               end
            end
            S_CALC: begin
               quo_q <= {quo_q[XLEN-BITS_PER_CYCLE-1:0], q_bits};
               rem_q <= rem_chain[BITS_PER_CYCLE];
               cnt_q <= cnt_q + CW'(BITS_PER_CYCLE);
            end
            S_DONE: begin
               result_q <= fixed_result;
            end
            default: ;
         endcase
      end
   end

   assign bus.result_o = last_cycle ? fixed_result : result_q;
   assign bus.hold_o   = bus.enable_i && !last_cycle && !reset;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, results, stall, abort and reset behaviour.
module tb_div_unit;

   logic clk;
   logic reset;
   logic stall;

   int n_cmp = 0;
   int n_bad = 0;

   div_if #(.XLEN(32)) bus ();

   div_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
      .clk  (clk),
      .reset(reset),
      .stall(stall),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Launches one request and waits for hold_o to fall; also records whether
   // result_o stayed at its previous value while the unit was busy.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic r,
                         input int st_at, input int st_len, input int ab_at,
                         input bit keep_en, input bit scramble,
                         output int lat, output logic [31:0] res, output bit held_ok);
      logic [31:0] prev;
      int c;
      bit done;
      @(posedge clk); #1;
      bus.first_operand_i  = a;
      bus.second_operand_i = b;
      bus.signed_i         = s;
      bus.rem_i            = r;
      bus.enable_i         = 1'b1;
      c       = 1;
      stall   = (st_len > 0) && (c >= st_at) && (c < st_at + st_len);
      prev    = bus.result_o;
      held_ok = 1'b1;
      lat     = -1;
      res     = 'x;
      done    = 1'b0;
      while (!done) begin
         @(negedge clk);
         if (!bus.hold_o) begin
            lat  = c;
            res  = bus.result_o;
            done = 1'b1;
         end else if (c >= 200) begin
            done = 1'b1;
         end else begin
            if (bus.result_o !== prev) held_ok = 1'b0;
            @(posedge clk); #1;
            c++;
            stall = (st_len > 0) && (c >= st_at) && (c < st_at + st_len);
            if (scramble && c == 3) begin
               bus.first_operand_i  = ~a;
               bus.second_operand_i = b + 32'd3;
               bus.signed_i         = ~s;
               bus.rem_i            = ~r;
            end
            if (ab_at > 0 && c == ab_at) bus.enable_i = 1'b0;
         end
      end
      stall = 1'b0;
      if (!keep_en) bus.enable_i = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      stall = 1'b0;
      bus.enable_i         = 1'b1;
      bus.first_operand_i  = 32'd100;
      bus.second_operand_i = 32'd7;
      bus.signed_i         = 1'b0;
      bus.rem_i            = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (bus.hold_o !== 1'b0) begin
         n_bad++; $display("FAIL reset_hold: got %b expected 0", bus.hold_o);
      end
      n_cmp++;
      if (bus.result_o !== 32'h0) begin
         n_bad++; $display("FAIL reset_result: got %h expected 00000000", bus.result_o);
      end
      @(posedge clk); #1;
      bus.enable_i = 1'b0;
      reset        = 1'b0;
   endtask

   task automatic test_unsigned;
      int lat; logic [31:0] res; bit ok;
      run_op(32'd100, 32'd7, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, lat, res, ok);
      n_cmp++;
      if (lat !== 34) begin n_bad++; $display("FAIL udiv_latency: got %0d expected 34", lat); end
      n_cmp++;
      if (res !== 32'd14) begin n_bad++; $display("FAIL udiv_100_7: got %h expected 0000000e", res); end
      n_cmp++;
      if (ok !== 1'b1) begin n_bad++; $display("FAIL udiv_result_held: got %b expected 1", ok); end
      run_op(32'd100, 32'd7, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0, lat, res, ok);
      n_cmp++;
      if (res !== 32'd2) begin n_bad++; $display("FAIL urem_100_7: got %h expected 00000002", res); end
      run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, lat, res, ok);
      n_cmp++;
      if (res !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL udiv_max_1: got %h expected ffffffff", res); end
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0, lat, res, ok);
      n_cmp++;
      if (res !== 32'h8000_0000) begin n_bad++; $display("FAIL urem_not_overflow: got %h expected 80000000", res); end
      n_cmp++;
      if (lat !== 34) begin n_bad++; $display("FAIL urem_not_overflow_latency: got %0d expected 34", lat); end
   endtask

   task automatic test_signed;
      int lat; logic [31:0] res; bit ok;
      run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, lat, res, ok);
      n_cmp++;
      if (res !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL sdiv_m7_2: got %h expected fffffffd", res); end
      run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 0, 0, 0, 1'b0, 1'b0, lat, res, ok);
      n_cmp++;
      if (res !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL srem_m7_2: got %h expected ffffffff", res); end
      run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, lat, res, ok);
      n_cmp++;
      if (res !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL sdiv_7_m2: got %h expected fffffffd", res); end
      run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 0, 0, 0, 1'b0, 1'b0, lat, res, ok);
      n_cmp++;
      if (res !== 32'd1) begin n_bad++; $display("FAIL srem_7_m2: got %h expected 00000001", res); end
      run_op(32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, lat, res, ok);
      n_cmp++;
      if (res !== 32'd2) begin n_bad++; $display("FAIL sdiv_m8_m3: got %h expected 00000002", res); end
      run_op(32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1, 1'b1, 0, 0, 0, 1'b0, 1'b0, lat, res, ok);
      n_cmp++;
      if (res !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL srem_m8_m3: got %h expected fffffffe", res); end
   endtask

   task automatic test_special;
      int lat; logic [31:0] res; bit ok;
      run_op(32'h1234, 32'h0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, lat, res, ok);
      n_cmp++;
      if (lat !== 2) begin n_bad++; $display("FAIL divzero_latency: got %0d expected 2", lat); end
      n_cmp++;
      if (res !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL divzero_quo: got %h expected ffffffff", res); end
      run_op(32'h1234, 32'h0, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0, lat, res, ok);
      n_cmp++;
      if (res !== 32'h1234) begin n_bad++; $display("FAIL divzero_rem: got %h expected 00001234", res); end
      run_op(32'hFFFF_FFFB, 32'h0, 1'b1, 1'b1, 0, 0, 0, 1'b0, 1'b0, lat, res, ok);
      n_cmp++;
      if (res !== 32'hFFFF_FFFB) begin n_bad++; $display("FAIL divzero_srem: got %h expected fffffffb", res); end
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, lat, res, ok);
      n_cmp++;
      if (lat !== 2) begin n_bad++; $display("FAIL overflow_latency: got %0d expected 2", lat); end
      n_cmp++;
      if (res !== 32'h8000_0000) begin n_bad++; $display("FAIL overflow_quo: got %h expected 80000000", res); end
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 0, 0, 0, 1'b0, 1'b0, lat, res, ok);
      n_cmp++;
      if (res !== 32'h0) begin n_bad++; $display("FAIL overflow_rem: got %h expected 00000000", res); end
   endtask

   task automatic test_stall;
      int lat; logic [31:0] res; bit ok;
      // Stall covers cycles where the iteration counter sits at 10; operands scrambled mid-run.
      run_op(32'd100, 32'd7, 1'b0, 1'b0, 12, 3, 0, 1'b0, 1'b1, lat, res, ok);
      n_cmp++;
      if (lat !== 37) begin n_bad++; $display("FAIL stall_latency: got %0d expected 37", lat); end
      n_cmp++;
      if (res !== 32'd14) begin n_bad++; $display("FAIL stall_result: got %h expected 0000000e", res); end
      n_cmp++;
      if (ok !== 1'b1) begin n_bad++; $display("FAIL stall_result_held: got %b expected 1", ok); end
      // Stall while in DONE with enable still high: unit must stay in DONE.
      run_op(32'd25, 32'd5, 1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0, lat, res, ok);
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         n_cmp++;
         if (bus.hold_o !== 1'b0) begin n_bad++; $display("FAIL stall_done_hold: got %b expected 0", bus.hold_o); end
         n_cmp++;
         if (bus.result_o !== 32'd5) begin n_bad++; $display("FAIL stall_done_result: got %h expected 00000005", bus.result_o); end
      end
      stall        = 1'b0;
      bus.enable_i = 1'b0;
   endtask

   task automatic test_abort;
      int lat; logic [31:0] res; bit ok;
      run_op(32'd25, 32'd5, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, lat, res, ok);
      run_op(32'd100, 32'd7, 1'b0, 1'b0, 0, 0, 7, 1'b0, 1'b0, lat, res, ok);
      n_cmp++;
      if (lat !== 7) begin n_bad++; $display("FAIL abort_hold_drop: got cycle %0d expected 7", lat); end
      n_cmp++;
      if (res !== 32'd5) begin n_bad++; $display("FAIL abort_result_kept: got %h expected 00000005", res); end
      run_op(32'd100, 32'd7, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, lat, res, ok);
      n_cmp++;
      if (lat !== 34) begin n_bad++; $display("FAIL after_abort_latency: got %0d expected 34", lat); end
      n_cmp++;
      if (res !== 32'd14) begin n_bad++; $display("FAIL after_abort_result: got %h expected 0000000e", res); end
   endtask

   task automatic test_back_to_back;
      int lat; logic [31:0] res; bit ok;
      run_op(32'd25, 32'd5, 1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0, lat, res, ok);
      n_cmp++;
      if (res !== 32'd5) begin n_bad++; $display("FAIL b2b_first: got %h expected 00000005", res); end
      run_op(32'd25, 32'd4, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0, lat, res, ok);
      n_cmp++;
      if (lat !== 34) begin n_bad++; $display("FAIL b2b_latency: got %0d expected 34", lat); end
      n_cmp++;
      if (res !== 32'd1) begin n_bad++; $display("FAIL b2b_second: got %h expected 00000001", res); end
      n_cmp++;
      if (ok !== 1'b1) begin n_bad++; $display("FAIL b2b_result_held: got %b expected 1", ok); end
   endtask

   task automatic test_reset_mid_calc;
      int lat; logic [31:0] res; bit ok;
      @(posedge clk); #1;
      bus.first_operand_i  = 32'd100;
      bus.second_operand_i = 32'd7;
      bus.signed_i         = 1'b0;
      bus.rem_i            = 1'b0;
      bus.enable_i         = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      n_cmp++;
      if (bus.hold_o !== 1'b0) begin n_bad++; $display("FAIL midreset_hold: got %b expected 0", bus.hold_o); end
      n_cmp++;
      if (bus.result_o !== 32'h0) begin n_bad++; $display("FAIL midreset_result: got %h expected 00000000", bus.result_o); end
      @(posedge clk); #1;
      bus.enable_i = 1'b0;
      reset        = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.result_o !== 32'h0) begin n_bad++; $display("FAIL postreset_result: got %h expected 00000000", bus.result_o); end
      run_op(32'd100, 32'd7, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, lat, res, ok);
      n_cmp++;
      if (lat !== 34) begin n_bad++; $display("FAIL postreset_latency: got %0d expected 34", lat); end
      n_cmp++;
      if (res !== 32'd14) begin n_bad++; $display("FAIL postreset_div: got %h expected 0000000e", res); end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_special();
      test_stall();
      test_abort();
      test_back_to_back();
      test_reset_mid_calc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
Multi-cycle integer divider. It is the inverse-operation companion of the multi-cycle multiplier and uses the same core-side handshake: enable_i, stall, hold_o and result_o.
- Covers RV32M DIV/DIVU/REM/REMU.
- Iterative restoring algorithm, BITS_PER_CYCLE quotient bits per cycle.
- Sits in the execute stage beside the multiplier. The pipeline keeps enable_i high and stalls while hold_o=1.

Parameters:
XLEN, 32, operand/result width
BITS_PER_CYCLE, 1, quotient bits resolved per CALC cycle; legal values 1, 2, 4 (must divide XLEN)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
stall  in  1  freeze: all internal registers hold their value
enable_i  in  1  divide request; held high until hold_o falls
first_operand_i  in  XLEN  dividend
second_operand_i  in  XLEN  divisor
signed_i  in  1  1 = signed (DIV/REM), 0 = unsigned
rem_i  in  1  1 = return remainder, 0 = return quotient
hold_o  out  1  busy; core must not advance
result_o  out  XLEN  quotient or remainder

Behaviour:
- Reset (async, active-high):
  - state=IDLE; quotient, remainder, divisor and counter registers = 0.
  - hold_o=0, result_o=0.
- States are one-hot (exactly one bit set): IDLE, CALC, DONE.
- IDLE:
  - enable_i=0 -> remain in IDLE.
  - enable_i=1 -> latch |dividend|, |divisor| (absolute values only when signed_i=1), the result signs, rem_i and signed_i; counter=0.
  - Normal operands -> next state CALC.
  - Special case -> next state DONE.
- Special cases (resolved in IDLE, no iterations):
  - divisor==0: quotient=all ones; remainder=dividend.
  - signed_i && dividend==0x80000000 && divisor==0xFFFFFFFF: quotient=0x80000000; remainder=0.
- CALC:
  - Each cycle performs BITS_PER_CYCLE restoring steps: shift partial remainder left, shift in next dividend MSB, trial-subtract divisor; if non-negative, keep the difference and shift in quotient bit 1.
  - Counter increments by BITS_PER_CYCLE; when the counter reaches XLEN-BITS_PER_CYCLE -> DONE.
- Sign fix-up (applied when signed_i=1):
  - quotient negated if dividend sign != divisor sign;
  - remainder takes the sign of the dividend.
- DONE:
  - result_o = sign-fixed quotient or remainder, selected by rem_i.
  - last_cycle=1, hold_o=0; next state IDLE.
- hold_o = enable_i && (state != DONE). It is combinational and therefore also high in IDLE on the request cycle.
- Latency, enable_i cycle to result cycle inclusive:
  - normal: XLEN/BITS_PER_CYCLE + 2 cycles (34 at defaults);
  - special cases: 2 cycles.
- result_o:
  - is driven from the final registers in DONE;
  - keeps its last value in IDLE and CALC, and does not glitch with operand changes.
- stall=1:
  - state, counter and datapath registers hold; the result is unaffected.
  - In DONE, hold_o stays 0 and the unit remains in DONE until stall drops.
- enable_i drops while in CALC: abort; next state IDLE (subject to stall); result_o keeps its previous value.
- Operands/mode inputs are sampled only in IDLE; later changes are ignored.
- Back-to-back requests: DONE -> IDLE -> a new request is accepted in IDLE. One idle-state cycle minimum between results.
- Reset asserted mid-CALC: immediate return to IDLE, hold_o=0, result_o=0.

Decomposition:
- Package div_pkg:
  - XLEN default;
  - one-hot state encoding constants (IDLE, CALC, DONE);
  - special-case constants (DIV_BY_ZERO_Q, INT_MIN, NEG_ONE).
- Sub-module div_step: combinational single restoring step.
  - In: partial remainder, dividend bit, divisor.
  - Out: new remainder, quotient bit.
  - Instantiated BITS_PER_CYCLE times in a chain.

Test Plan:
- Unsigned divide, quotient: 100/7, signed_i=0, rem_i=0 -> hold_o high 33 cycles, then result_o=14 in cycle 34; unit returns to IDLE.
- Signed divide, quotient and remainder: -7/2, signed_i=1 -> rem_i=0 gives result_o=0xFFFFFFFD; rem_i=1 gives result_o=0xFFFFFFFF.
- Divide by zero: 0x1234/0 -> result 0xFFFFFFFF (rem_i=0) or 0x1234 (rem_i=1), in 2 cycles.
- Signed overflow: 0x80000000/0xFFFFFFFF, signed_i=1 -> quotient 0x80000000, remainder 0, in 2 cycles.
- Stall mid-CALC: 3 stall cycles inserted at iteration 10 of 100/7 -> latency 37, result still 14, state frozen during stall.
- Abort and reset: enable_i dropped at iteration 5 -> IDLE next cycle, result_o unchanged. reset pulsed mid-CALC -> hold_o=0, result_o=0 immediately.
